bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
Parallel-to-serial front end that feeds the serial Mealy sequence-detector stage.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits one bit per clock on ser_out; framing strobes mark word boundaries.
- A one-word holding register lets consecutive words stream with zero idle cycles between them.
- When no word is in flight, ser_out drives IDLE_BIT, so the downstream detector always sees a defined bit every cycle.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_BIT, 0, value driven on ser_out while no word is shifting.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
in_data  in  WIDTH  parallel word to serialize.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  block can accept a word this cycle.
abort  in  1  synchronous flush of the hold register and the shifter.
ser_out  out  1  serial bit stream to the downstream detector.
ser_valid  out  1  ser_out carries a data bit (not idle fill).
sof  out  1  high on the first bit of each word.
eof  out  1  high on the last bit of each word.
busy  out  1  a word is shifting or held.

Behaviour:
- Storage elements:
  - hold_data[WIDTH] and hold_valid;
  - shreg[WIDTH];
  - bitcnt, clog2(WIDTH) bits, counting up 0..WIDTH-1;
  - active, the shifter state flag.
- FSM has two states, IDLE (active=0) and SHIFT (active=1).
- in_ready = !hold_valid. It is combinational from flops only and never depends on in_valid.
- Handshake fires when in_valid && in_ready at a rising edge. hold_data captures in_data and hold_valid sets.
- Shifter load: at a rising edge where hold_valid=1 and (state=IDLE, or state=SHIFT with bitcnt=WIDTH-1):
  - shreg <= hold_data, bitcnt <= 0, active <= 1;
  - hold_valid clears, unless a new handshake fires on the same edge, in which case it stays set with the new data.
- Latency: handshake at edge E0 → hold valid after E0 → load at E1 → first bit visible on ser_out in the cycle after E1. Fixed 2-cycle latency from handshake to first bit.
- Throughput: back-to-back words produce continuous ser_valid=1 with no gap. The last bit of word N is followed immediately by the first bit of word N+1.
- Shifting in SHIFT state:
  - each edge shifts shreg one position (left if MSB_FIRST, else right; zero fill) and increments bitcnt;
  - at bitcnt=WIDTH-1 with hold_valid=0, the block returns to IDLE.
- Output derivation, from flops only:
  - ser_out = active ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
  - ser_valid = active;
  - sof = active && bitcnt==0;
  - eof = active && bitcnt==WIDTH-1;
  - busy = active || hold_valid.
- abort, sampled at a rising edge:
  - clears hold_valid and active and zeroes bitcnt;
  - a handshake on the same edge is dropped, and in_ready=1 on the next cycle;
  - takes priority over load and shift.
- Reset (rst=0, asynchronous): hold_valid=0, active=0, bitcnt=0, shreg=0, hold_data=0.
  - Outputs during reset: ser_out=IDLE_BIT, ser_valid=0, sof=0, eof=0, busy=0, in_ready=1.
  - A word in flight is discarded, with no partial bits after reset release.
- in_valid while in_ready=0 is ignored. The source must hold in_data/in_valid until in_ready.
- For WIDTH=2, sof and eof alternate on consecutive cycles. sof and eof are never high together because WIDTH≥2.

Decomposition:
- Shared package holds the parameter defaults WIDTH_DEF=8 and IDLE_BIT_DEF=0, and state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1. The downstream detector reuses the same package.
- No sub-module. The hold register and shifter are small enough to live in one module.

Test Plan:
- Reset, then idle 5 cycles → ser_out=0, ser_valid=0, in_ready=1, busy=0 throughout.
- WIDTH=8, MSB_FIRST=1, send 8'hB4 → two cycles after the handshake, ser_out=1,0,1,1,0,1,0,0 on 8 consecutive cycles; sof on bit 1, eof on bit 8; then ser_valid=0.
- Back-to-back 8'hFF then 8'h00, in_valid held high → 16 contiguous ser_valid cycles; in_ready drops after the second accept; sof pulses exactly 8 cycles apart.
- MSB_FIRST=0, send 8'h01 → first serial bit 1, then seven 0s.
- abort at bit 3 of a word, with a second word held → ser_valid=0 the next cycle, busy=0, in_ready=1; no further bits of either word appear.
- rst asserted mid-word (bit 5) → ser_out=IDLE_BIT immediately (asynchronous); after release, a new word 8'hA5 serializes correctly from its first bit.
- End-to-end, with the serializer driving the detector: send 8'b1001_1000 → detector out pulses at the expected bit positions; the idle fill introduces no false detection.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector.
package bit_serializer_pkg;
  localparam int WIDTH_DEF    = 8;
  localparam bit IDLE_BIT_DEF = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word hold register feeding a shifter,
// so consecutive words stream out with no idle bits between them.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] hold_data, hold_data_n;
  logic             hold_valid, hold_valid_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    bitcnt, bitcnt_n;

  logic active, fire, at_last, load;
  logic [WIDTH-1:0] shifted;

  assign active  = (state == ST_SHIFT);
  assign fire    = in_valid && in_ready;
  assign at_last = (bitcnt == LAST);
  // Reloading on the last bit is what makes back-to-back words gapless.
  assign load    = hold_valid && (!active || at_last);
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      shreg      <= '0;
      bitcnt     <= '0;
    end else begin
      state      <= state_n;
      hold_data  <= hold_data_n;
      hold_valid <= hold_valid_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    hold_data_n  = hold_data;
    hold_valid_n = hold_valid;
    shreg_n      = shreg;
    bitcnt_n     = bitcnt;
    if (abort) begin
      // Flush wins over everything, including a handshake on this edge.
      hold_valid_n = 1'b0;
      state_n      = ST_IDLE;
      bitcnt_n     = '0;
    end else begin
      if (fire) begin
        hold_data_n  = in_data;
        hold_valid_n = 1'b1;
      end
      if (load) begin
        shreg_n      = hold_data;
        bitcnt_n     = '0;
        state_n      = ST_SHIFT;
        hold_valid_n = fire;
      end else if (active) begin
        shreg_n  = shifted;
        bitcnt_n = bitcnt + CW'(1);
        if (at_last) begin
          state_n  = ST_IDLE;
          bitcnt_n = '0;
        end
      end
    end
  end

  assign in_ready  = !hold_valid;
  assign ser_out   = active ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
  assign ser_valid = active;
  assign sof       = active && (bitcnt == '0);
  assign eof       = active && at_last;
  assign busy      = active || hold_valid;
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: MSB-first (idle 0) and LSB-first (idle 1) serializers share
// the stimulus; each accepted word schedules its bits at absolute cycle numbers.
module tb_bit_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic       rdy_m, so_m, sv_m, sof_m, eof_m, busy_m;
  logic       rdy_l, so_l, sv_l, sof_l, eof_l, busy_l;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int last_end = 0;

  typedef struct {
    int         cyc;
    logic [7:0] w;
    int         idx;
  } bit_t;
  bit_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .abort(abort), .ser_out(so_m), .ser_valid(sv_m), .sof(sof_m), .eof(eof_m), .busy(busy_m));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .abort(abort), .ser_out(so_l), .ser_valid(sv_l), .sof(sof_l), .eof(eof_l), .busy(busy_l));

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got {valid,out,sof,eof,busy,ready}=%b expected %b",
               name, ecnt, got, exp);
    end
  endtask

  // Monitor: compares both DUTs against the scheduled bit for this cycle.
  always @(negedge clk) begin
    logic       have, held;
    bit_t       e;
    logic [5:0] exp_m, exp_l;
    have = 1'b0;
    held = 1'b0;
    e = '{cyc: 0, w: 8'h00, idx: 0};
    if (q.size() > 0 && q[0].cyc == ecnt) begin
      e = q.pop_front();
      have = 1'b1;
    end
    foreach (q[i]) if (q[i].idx == 0 && q[i].cyc > ecnt) held = 1'b1;
    if (have) begin
      exp_m = {1'b1, e.w[7 - e.idx], e.idx == 0, e.idx == 7, 1'b1, !held};
      exp_l = {1'b1, e.w[e.idx],     e.idx == 0, e.idx == 7, 1'b1, !held};
    end else begin
      exp_m = {1'b0, 1'b0, 1'b0, 1'b0, q.size() > 0, !held};
      exp_l = {1'b0, 1'b1, 1'b0, 1'b0, q.size() > 0, !held};
    end
    check("msb_first", {sv_m, so_m, sof_m, eof_m, busy_m, rdy_m}, exp_m);
    check("lsb_first", {sv_l, so_l, sof_l, eof_l, busy_l, rdy_l}, exp_l);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Accepted at the next edge: load one edge later, first bit the cycle after,
  // unless the previous word is still going out.
  task automatic schedule(input logic [7:0] w);
    int start;
    start = (ecnt + 2 > last_end + 1) ? ecnt + 2 : last_end + 1;
    for (int i = 0; i < 8; i++) q.push_back('{cyc: start + i, w: w, idx: i});
    last_end = start + 7;
  endtask

  task automatic send(input logic [7:0] w);
    bit done;
    done = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      if (rdy_m) begin
        schedule(w);
        done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout word=%h never accepted (expected acceptance within 40 cycles)", w);
    end
  endtask

  task automatic flush_model();
    q.delete();
    last_end = 0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    flush_model();
    step();
    abort = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b1;
    repeat (5) step();

    send(8'hB4);
    repeat (12) step();

    send(8'hFF);
    send(8'h00);
    repeat (20) step();

    send(8'h01);
    repeat (12) step();

    // Abort with one word shifting and a second one held.
    send(8'h5A);
    send(8'hC3);
    step();
    do_abort();
    repeat (12) step();

    // Asynchronous reset in the middle of a word.
    send(8'h3C);
    repeat (6) step();
    #3 rst = 1'b0;
    flush_model();
    #1;
    check("async_rst_m", {sv_m, so_m, sof_m, eof_m, busy_m, rdy_m}, 6'b000001);
    check("async_rst_l", {sv_l, so_l, sof_l, eof_l, busy_l, rdy_l}, 6'b010001);
    repeat (3) step();
    rst = 1'b1;
    step();
    send(8'hA5);
    repeat (12) step();

    for (int n = 0; n < 60; n++) begin
      send(8'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 8)) step();
        do_abort();
      end else begin
        repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 10) : 0) step();
      end
    end
    repeat (25) step();

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d scheduled bits never appeared (expected 0)", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
